// File: rtl/sha2_pkg.sv
// Shared SHA-2 sigma definitions: mode encoding and rotate/shift amount tables
// for the 32-bit (SHA-256) and 64-bit (SHA-512) word sizes.
package sha2_pkg;

  typedef enum logic [1:0] {
    MODE_BSIG0 = 2'd0,
    MODE_BSIG1 = 2'd1,
    MODE_SSIG0 = 2'd2,
    MODE_SSIG1 = 2'd3
  } sigma_mode_e;

  localparam int unsigned NUM_MODES = 4;

  // Per mode: {first rotate, second rotate, third rotate-or-shift}
  localparam int unsigned SHA256_AMT [NUM_MODES][3] = '{
    '{2, 13, 22},
    '{6, 11, 25},
    '{7, 18, 3},
    '{17, 19, 10}
  };

  localparam int unsigned SHA512_AMT [NUM_MODES][3] = '{
    '{28, 34, 39},
    '{14, 18, 41},
    '{1, 8, 7},
    '{19, 61, 6}
  };

  function automatic int unsigned sigma_amt(input int unsigned width,
                                            input logic [1:0] mode,
                                            input logic [1:0] term);
    if (width == 64) sigma_amt = SHA512_AMT[mode][term];
    else             sigma_amt = SHA256_AMT[mode][term];
  endfunction

  // The small sigmas use a logical shift for their third term.
  function automatic logic is_shift_term(input logic [1:0] mode);
    is_shift_term = (mode == MODE_SSIG0) || (mode == MODE_SSIG1);
  endfunction

endpackage

// File: rtl/sha2_sigma_mix.sv
// Combinational SHA-2 sigma function: computes all four variants with
// constant rotates/shifts and selects one by mode.
module sha2_sigma_mix
  import sha2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  sigma_mode_e      mode_i,
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] fn_res [NUM_MODES];

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_fn
    localparam logic [1:0] MODE = 2'(gi);
    localparam int unsigned R0 = sigma_amt(WIDTH, MODE, 2'd0);
    localparam int unsigned R1 = sigma_amt(WIDTH, MODE, 2'd1);
    localparam int unsigned R2 = sigma_amt(WIDTH, MODE, 2'd2);

    logic [WIDTH-1:0] t0, t1, t2;
    assign t0 = (word_i >> R0) | (word_i << (WIDTH - R0));
    assign t1 = (word_i >> R1) | (word_i << (WIDTH - R1));

    if (is_shift_term(MODE)) begin : g_shr
      assign t2 = word_i >> R2;
    end else begin : g_rot
      assign t2 = (word_i >> R2) | (word_i << (WIDTH - R2));
    end

    assign fn_res[gi] = t0 ^ t1 ^ t2;
  end

  assign result_o = fn_res[2'(mode_i)];

endmodule

// File: rtl/sha2_sigma_pipe.sv
// Two-stage valid/ready pipeline around the SHA-2 sigma function: stage 1
// captures the operand, stage 2 captures the result; tag travels alongside.
module sha2_sigma_pipe
  import sha2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("sha2_sigma_pipe: WIDTH must be 32 or 64");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  sigma_mode_e      s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] mix_res;

  // Whole pipe moves as one; a stalled output freezes both stages.
  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = advance && !flush;
  assign accept   = in_valid && in_ready;

  sha2_sigma_mix #(.WIDTH(WIDTH)) u_mix (
    .mode_i   (s1_mode_q),
    .word_i   (s1_data_q),
    .result_o (mix_res)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (advance) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = in_data;
        s1_mode_d = sigma_mode_e'(in_mode);
        s1_tag_d  = in_tag;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = mix_res;
        s2_tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_BSIG0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_sha2_sigma_pipe.sv
// Self-checking bench for sha2_sigma_pipe: 32-bit and 64-bit instances,
// table-driven vectors through a scoreboard, plus flush and reset sequences.
module tb_sha2_sigma_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;

  logic        v_flush;
  logic        v_in_valid, v_in_ready;
  logic [1:0]  v_in_mode;
  logic [63:0] v_in_data;
  logic [3:0]  v_in_tag;
  logic        v_out_valid, v_out_ready;
  logic [63:0] v_out_data;
  logic [3:0]  v_out_tag;
  logic        v_busy;

  sha2_sigma_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  sha2_sigma_pipe #(.WIDTH(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(v_flush),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_mode(v_in_mode),
    .in_data(v_in_data), .in_tag(v_in_tag),
    .out_valid(v_out_valid), .out_ready(v_out_ready),
    .out_data(v_out_data), .out_tag(v_out_tag), .busy(v_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  vec_t vec32 [10];
  vec_t vec64 [4];
  exp_t sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Streams vec32[start +: n] with tags tag_base+i; out_ready random if rnd.
  task automatic run_stream(input int start, input int n, input int tag_base, input bit rnd,
                            output int first_acc, output int first_out, output int last_out);
    int idx = 0;
    int popped = 0;
    int cyc = 0;
    logic hold_v = 1'b0;
    logic [31:0] hold_d = '0;
    logic [3:0] hold_t = '0;
    exp_t e;
    first_acc = -1;
    first_out = -1;
    last_out  = -1;
    while ((idx < n || popped < n) && cyc < 200) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < n) begin
        in_valid = 1'b1;
        in_mode  = vec32[start + idx].mode;
        in_data  = vec32[start + idx].data[31:0];
        in_tag   = 4'(tag_base + idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_v) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(hold_d));
        check("stall_tag", 64'(out_tag), 64'(hold_t));
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_t = out_tag;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(out_tag), 64'hDEAD);
        end else begin
          e = sb_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_tag", 64'(out_tag), 64'(e.tag));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        popped++;
      end
      if (in_valid && in_ready) begin
        e.data = vec32[start + idx].exp[31:0];
        e.tag  = in_tag;
        sb_q.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_popped", 64'(popped), 64'(n));
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  initial begin
    int fa, fo, lo, lat, seen;

    vec32[0] = '{2'd0, 64'h1, 64'h40080400};
    vec32[1] = '{2'd1, 64'h1, 64'h04200080};
    vec32[2] = '{2'd2, 64'h1, 64'h02004000};
    vec32[3] = '{2'd3, 64'h1, 64'h0000A000};
    vec32[4] = '{2'd2, 64'h80000000, 64'h11002000};
    vec32[5] = '{2'd1, 64'h80000000, 64'h02100040};
    vec32[6] = '{2'd3, 64'h80000000, 64'h00205000};
    vec32[7] = '{2'd0, 64'h80000000, 64'h20040200};
    vec32[8] = '{2'd2, 64'hFFFFFFFF, 64'h1FFFFFFF};
    vec32[9] = '{2'd3, 64'hFFFFFFFF, 64'h003FFFFF};
    vec64[0] = '{2'd0, 64'h1, 64'h0000001042000000};
    vec64[1] = '{2'd1, 64'h1, 64'h0004400000800000};
    vec64[2] = '{2'd2, 64'h1, 64'h8100000000000000};
    vec64[3] = '{2'd3, 64'h1, 64'h0000200000000008};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = '0; in_data = '0; in_tag = '0;
    out_ready = 1'b1;
    v_flush = 1'b0; v_in_valid = 1'b0; v_in_mode = '0; v_in_data = '0; v_in_tag = '0;
    v_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst64_out_valid", 64'(v_out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back modes on 0x00000001: latency 2, then one result per cycle.
    run_stream(0, 4, 0, 1'b0, fa, fo, lo);
    check("first_latency", 64'(fo - fa), 64'd2);
    check("consecutive", 64'(lo - fo), 64'd3);
    $display("stream basic: accept@%0d first_out@%0d last_out@%0d", fa, fo, lo);

    run_stream(4, 6, 4, 1'b0, fa, fo, lo);
    $display("stream table: accept@%0d first_out@%0d last_out@%0d", fa, fo, lo);

    // Tags 1..8 with random backpressure.
    run_stream(0, 8, 1, 1'b1, fa, fo, lo);
    $display("stream random-ready: accept@%0d first_out@%0d last_out@%0d", fa, fo, lo);

    repeat (3) @(negedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);

    // 64-bit instance, one word at a time.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v_in_valid = 1'b1;
      v_in_mode  = vec64[i].mode;
      v_in_data  = vec64[i].data;
      v_in_tag   = 4'(i + 3);
      #1;
      check("w64_in_ready", 64'(v_in_ready), 64'd1);
      @(negedge clk);
      v_in_valid = 1'b0;
      lat = 1;
      #1;
      while (!v_out_valid && lat < 10) begin
        @(negedge clk);
        #1;
        lat++;
      end
      check("w64_latency", 64'(lat), 64'd2);
      check("w64_data", v_out_data, vec64[i].exp);
      check("w64_tag", 64'(v_out_tag), 64'(i + 3));
      $display("w64 mode %0d data 0x%0h -> 0x%0h tag %0d", vec64[i].mode, vec64[i].data, v_out_data, v_out_tag);
    end
    @(negedge clk);

    // Flush with two words in flight and a simultaneous offer.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'd0; in_data = 32'h1; in_tag = 4'd9;
    @(negedge clk);
    in_data = 32'h2; in_tag = 4'd10;
    @(negedge clk);
    in_data = 32'h3; in_tag = 4'd11;
    #1;
    check("preflush_busy", 64'(busy), 64'd1);
    check("preflush_out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("postflush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
      #1;
    end
    check("postflush_no_output", 64'(seen), 64'd0);
    $display("flush: outputs seen after flush = %0d", seen);

    // Async reset while an output is stalled.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd2; in_data = 32'h80000000; in_tag = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    #1;
    check("stalled_out_valid", 64'(out_valid), 64'd1);
    check("stalled_out_data", 64'(out_data), 64'h11002000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data", 64'(out_data), 64'd0);
    check("async_rst_out_tag", 64'(out_tag), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    $display("async reset: out_valid=%0d out_data=0x%0h busy=%0d", out_valid, out_data, busy);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha2_sigma_pipe.md
SHA2_SIGMA_PIPE -- requirements
Module: sha2_sigma_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width; legal values 32 (SHA-256) and 64 (SHA-512), any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each word.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  synchronous clear of all in-flight words.
REQ-006 The block SHALL have port in_valid  input  1  input word offered.
REQ-007 The block SHALL have port in_ready  output  1  block accepts the input word this cycle.
REQ-008 The block SHALL have port in_mode  input  2  function select: 0 = Sigma0, 1 = Sigma1, 2 = sigma0, 3 = sigma1.
REQ-009 The block SHALL have port in_data  input  WIDTH  operand word.
REQ-010 The block SHALL have port in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-011 The block SHALL have port out_valid  output  1  result word offered.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-013 The block SHALL have port out_data  output  WIDTH  function result.
REQ-014 The block SHALL have port out_tag  output  TAG_W  tag of the result word.
REQ-015 The block SHALL have port busy  output  1  high while any stage holds a valid word.

Function
REQ-016 For WIDTH=32, the functions SHALL be: Sigma0 = ROTR2^ROTR13^ROTR22; Sigma1 = ROTR6^ROTR11^ROTR25; sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
REQ-017 For WIDTH=64, the functions SHALL be: Sigma0 = ROTR28^ROTR34^ROTR39; Sigma1 = ROTR14^ROTR18^ROTR41; sigma0 = ROTR1^ROTR8^SHR7; sigma1 = ROTR19^ROTR61^SHR6.
REQ-018 ROTR SHALL be a circular right rotate over WIDTH bits; SHR SHALL be a logical right shift with zero fill.
REQ-019 The datapath SHALL be a 2-stage pipeline: stage 1 registers in_data, in_mode and in_tag; stage 2 registers the computed result and the tag.
REQ-020 An input SHALL be accepted on a cycle where in_valid and in_ready are both high.
REQ-021 Latency SHALL be exactly 2 cycles from the accept edge to out_valid, provided there is no backpressure.
REQ-022 The pipeline SHALL advance whenever (!out_valid || out_ready) is high, and in_ready SHALL equal that term combinationally.
REQ-023 Throughput SHALL be one word per cycle while out_ready is held high.
REQ-024 When out_valid=1 and out_ready=0, out_data, out_tag and stage-1 contents SHALL hold stable, and no input SHALL be accepted.
REQ-025 Bubbles SHALL be collapsed only by the advance rule; word ordering SHALL be preserved FIFO.
REQ-026 flush=1 SHALL clear both stage valid bits at the next edge and SHALL take priority over a simultaneous accept, which is dropped; in_ready SHALL be 0 while flush=1.
REQ-027 busy SHALL be the OR of the stage-1 and stage-2 valid bits.
REQ-028 in_mode SHALL be sampled with in_data; a mode change between consecutive words SHALL need no idle cycle.

Reset
REQ-029 While rst_n=0, all valid bits, out_data and out_tag SHALL be 0; consequently out_valid=0 and busy=0, and in_ready SHALL be 1 once rst_n=1.
REQ-030 Assertion of rst_n mid-operation SHALL discard all in-flight words immediately, with no partial output.

Structure
REQ-031 Package sha2_pkg SHALL hold the mode enumeration and the per-WIDTH rotate/shift constant tables, to be shared with the message-schedule and compression blocks.
REQ-032 The combinational function SHALL be a single sub-module, sha2_sigma_mix (WIDTH, mode, word in, result out), instantiated between stage 1 and stage 2.

Verification
REQ-033 The bench SHALL cover: WIDTH=32, in_data=0x00000001, modes 0/1/2/3 back-to-back -> out_data 0x40080400, 0x04200080, 0x02004000, 0x0000A000 on consecutive cycles, with the first result 2 cycles after the first accept.
REQ-034 The bench SHALL cover: WIDTH=32, sigma0 of 0x80000000 -> 0x11002000, confirming SHR zero fill against the rotate terms.
REQ-035 The bench SHALL cover: WIDTH=64, Sigma0 of 0x0000000000000001 -> 0x0000001042000000.
REQ-036 The bench SHALL cover: stream tags 1..8 while out_ready toggles at random -> all 8 results arrive in order with correct tags, out_data stable while stalled, and no duplicates or drops.
REQ-037 The bench SHALL cover: two words in flight, then flush=1 together with in_valid=1 -> no out_valid afterwards and busy=0 the next cycle.
REQ-038 The bench SHALL cover: rst_n asserted low while out_valid=1 and out_ready=0 -> out_valid, out_data and busy go to 0 immediately, without waiting for clk.
